// File: rtl/gray_ptr_sync_if.sv
// Bundles the Gray pointer input, error clear and all synchronised outputs of gray_ptr_sync.
// The slave modport is the synchroniser side; master is the logic that feeds and consumes it.
interface gray_ptr_sync_if #(
   parameter int ADDR_WIDTH = 4
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0] ptr_gray;
   logic          err_clr;
   logic [PW-1:0] sync_gray;
   logic [PW-1:0] sync_bin;
   logic          changed;
   logic [PW-1:0] step;
   logic          gray_err;

   modport master (
      output ptr_gray,
      output err_clr,
      input  sync_gray,
      input  sync_bin,
      input  changed,
      input  step,
      input  gray_err
   );

   modport slave (
      input  ptr_gray,
      input  err_clr,
      output sync_gray,
      output sync_bin,
      output changed,
      output step,
      output gray_err
   );

endinterface

// File: rtl/gray_ptr_sync.sv
// Destination-domain synchroniser for an async-FIFO Gray pointer: metastability chain, binary decode,
// per-sample advance count with change strobe, and a sticky detector for illegal pointer movement.
module gray_ptr_sync #(
   parameter int          ADDR_WIDTH  = 4,
   parameter int          SYNC_STAGES = 2,
   parameter int unsigned MAX_STEP    = 1
) (
   input  logic            clk,
   input  logic            reset,
   gray_ptr_sync_if.slave  bus
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int CW = (PW > 32) ? PW : 32;

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gBadStages
         $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
      end
   endgenerate

   logic [PW-1:0] stage_q [SYNC_STAGES];
   logic [PW-1:0] syncGray;

   logic [PW-1:0] syncBin_q;
   logic [PW-1:0] prevGray_q;
   logic [PW-1:0] step_q;
   logic          changed_q;
   logic          grayErr_q;

   logic [PW-1:0] decodedBin;
   logic [PW-1:0] delta;
   logic [PW-1:0] grayDiff;
   logic [CW-1:0] deltaWide;
   logic          multiBit;
   logic          tooFar;
   logic          grayErr_d;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Pure flop chain; any logic between stages would defeat the metastability settling time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= bus.ptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign syncGray = stage_q[SYNC_STAGES-1];

   // A legal Gray move changes at most one bit; grayDiff with more than one set bit is illegal.
   always_comb begin
      decodedBin = gray2bin(syncGray);
      delta      = decodedBin - syncBin_q;
      grayDiff   = syncGray ^ prevGray_q;
      multiBit   = (grayDiff & (grayDiff - 1'b1)) != '0;
      deltaWide  = CW'(delta);
      tooFar     = deltaWide > CW'(MAX_STEP);
      grayErr_d  = grayErr_q;
      if (multiBit || tooFar) begin
         grayErr_d = 1'b1;
      end else if (bus.err_clr) begin
         grayErr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncBin_q  <= '0;
         prevGray_q <= '0;
         step_q     <= '0;
         changed_q  <= 1'b0;
         grayErr_q  <= 1'b0;
      end else begin
         syncBin_q  <= decodedBin;
         prevGray_q <= syncGray;
         step_q     <= delta;
         changed_q  <= (delta != '0);
         grayErr_q  <= grayErr_d;
      end
   end

   assign bus.sync_gray = syncGray;
   assign bus.sync_bin  = syncBin_q;
   assign bus.step      = step_q;
   assign bus.changed   = changed_q;
   assign bus.gray_err  = grayErr_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Runs three synchronisers (2, 3 and 4 stages) from one stimulus against a history-based model,
// with hand-computed latency, wrap, error and reset expectations on top.
module tb_gray_ptr_sync;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] ptrGray;
   logic       errClr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gray_ptr_sync_if #(.ADDR_WIDTH(4)) busS2 ();
   gray_ptr_sync_if #(.ADDR_WIDTH(4)) busS3 ();
   gray_ptr_sync_if #(.ADDR_WIDTH(4)) busS4 ();

   assign busS2.ptr_gray = ptrGray;
   assign busS3.ptr_gray = ptrGray;
   assign busS4.ptr_gray = ptrGray;
   assign busS2.err_clr  = errClr;
   assign busS3.err_clr  = errClr;
   assign busS4.err_clr  = errClr;

   gray_ptr_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .MAX_STEP(1)) dutS2 (.clk(clk), .reset(reset), .bus(busS2));
   gray_ptr_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(3), .MAX_STEP(1)) dutS3 (.clk(clk), .reset(reset), .bus(busS3));
   gray_ptr_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(4), .MAX_STEP(1)) dutS4 (.clk(clk), .reset(reset), .bus(busS4));

   logic [4:0] obsGray    [3];
   logic [4:0] obsBin     [3];
   logic [4:0] obsStep    [3];
   logic       obsChanged [3];
   logic       obsErr     [3];

   assign obsGray[0] = busS2.sync_gray;  assign obsBin[0] = busS2.sync_bin;  assign obsStep[0] = busS2.step;
   assign obsGray[1] = busS3.sync_gray;  assign obsBin[1] = busS3.sync_bin;  assign obsStep[1] = busS3.step;
   assign obsGray[2] = busS4.sync_gray;  assign obsBin[2] = busS4.sync_bin;  assign obsStep[2] = busS4.step;
   assign obsChanged[0] = busS2.changed; assign obsErr[0] = busS2.gray_err;
   assign obsChanged[1] = busS3.changed; assign obsErr[1] = busS3.gray_err;
   assign obsChanged[2] = busS4.changed; assign obsErr[2] = busS4.gray_err;

   // Model state: every input value sampled since reset, plus the expected sticky error per instance.
   logic [4:0] hist [$];
   logic       modelErr [3] = '{1'b0, 1'b0, 1'b0};

   function automatic logic [4:0] grayOf(input int b);
      return 5'(b ^ (b >> 1));
   endfunction

   function automatic logic [4:0] binOf(input logic [4:0] g);
      for (int b = 0; b < 32; b++) begin
         if (grayOf(b) == g) return 5'(b);
      end
      return 5'd0;
   endfunction

   function automatic logic [4:0] histAt(input int j);
      if (j >= 1 && j <= hist.size()) return hist[j-1];
      return 5'd0;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         hist.delete();
         for (int k = 0; k < 3; k++) modelErr[k] <= 1'b0;
      end else begin
         hist.push_back(ptrGray);
         for (int k = 0; k < 3; k++) begin
            automatic int         s    = k + 2;
            automatic int         e    = hist.size();
            automatic logic [4:0] gNew = histAt(e - s);
            automatic logic [4:0] gOld = histAt(e - s - 1);
            automatic logic [4:0] d    = binOf(gNew) - binOf(gOld);
            if ($countones(gNew ^ gOld) > 1 || d > 5'd1) modelErr[k] <= 1'b1;
            else if (errClr) modelErr[k] <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         automatic int         s       = k + 2;
         automatic int         e       = hist.size();
         automatic logic [4:0] expGray = histAt(e - s + 1);
         automatic logic [4:0] expBin  = binOf(histAt(e - s));
         automatic logic [4:0] expStep = expBin - binOf(histAt(e - s - 1));
         checkOutput($sformatf("model S%0d sync_gray", s), int'(obsGray[k]), int'(expGray));
         checkOutput($sformatf("model S%0d sync_bin", s), int'(obsBin[k]), int'(expBin));
         checkOutput($sformatf("model S%0d step", s), int'(obsStep[k]), int'(expStep));
         checkOutput($sformatf("model S%0d changed", s), int'(obsChanged[k]), int'(expStep != 5'd0));
         checkOutput($sformatf("model S%0d gray_err", s), int'(obsErr[k]), int'(modelErr[k]));
      end
   end

   task automatic applyStimulus(input logic [4:0] g);
      @(negedge clk);
      ptrGray = g;
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("%s S%0d gray", tag, k + 2), int'(obsGray[k]), 0);
         checkOutput($sformatf("%s S%0d bin", tag, k + 2), int'(obsBin[k]), 0);
         checkOutput($sformatf("%s S%0d step", tag, k + 2), int'(obsStep[k]), 0);
         checkOutput($sformatf("%s S%0d changed", tag, k + 2), int'(obsChanged[k]), 0);
         checkOutput($sformatf("%s S%0d err", tag, k + 2), int'(obsErr[k]), 0);
      end
   endtask

   initial begin
      reset   = 1'b1;
      ptrGray = 5'd0;
      errClr  = 1'b0;
      @(negedge clk);
      #1;
      checkAllZero("in reset");
      @(negedge clk);
      reset = 1'b0;

      // Idle input after reset: nothing moves.
      repeat (10) @(negedge clk);
      checkAllZero("idle");

      // Single step 0 -> 1; latency grows with stage count.
      applyStimulus(5'b00001);
      waitEdge();
      checkOutput("lat e1 S2 gray", int'(obsGray[0]), 0);
      waitEdge();
      checkOutput("lat e2 S2 gray", int'(obsGray[0]), 1);
      checkOutput("lat e2 S3 gray", int'(obsGray[1]), 0);
      checkOutput("lat e2 S2 changed", int'(obsChanged[0]), 0);
      waitEdge();
      checkOutput("lat e3 S2 bin", int'(obsBin[0]), 1);
      checkOutput("lat e3 S2 changed", int'(obsChanged[0]), 1);
      checkOutput("lat e3 S2 step", int'(obsStep[0]), 1);
      checkOutput("lat e3 S3 gray", int'(obsGray[1]), 1);
      checkOutput("lat e3 S3 bin", int'(obsBin[1]), 0);
      waitEdge();
      checkOutput("lat e4 S2 changed", int'(obsChanged[0]), 0);
      checkOutput("lat e4 S3 bin", int'(obsBin[1]), 1);
      checkOutput("lat e4 S3 changed", int'(obsChanged[1]), 1);
      checkOutput("lat e4 S4 gray", int'(obsGray[2]), 1);
      checkOutput("lat e4 S4 bin", int'(obsBin[2]), 0);
      waitEdge();
      checkOutput("lat e5 S4 bin", int'(obsBin[2]), 1);
      checkOutput("lat e5 S4 step", int'(obsStep[2]), 1);

      // Walk the full code space and wrap 10000 -> 00000.
      for (int b = 2; b < 32; b++) begin
         applyStimulus(grayOf(b));
         repeat (3) @(negedge clk);
      end
      checkOutput("pre-wrap S2 bin", int'(obsBin[0]), 31);
      applyStimulus(5'b00000);
      repeat (3) waitEdge();
      checkOutput("wrap S2 bin", int'(obsBin[0]), 0);
      checkOutput("wrap S2 step", int'(obsStep[0]), 1);
      checkOutput("wrap S2 changed", int'(obsChanged[0]), 1);
      checkOutput("wrap S2 err", int'(obsErr[0]), 0);
      repeat (2) waitEdge();
      checkOutput("wrap S4 bin", int'(obsBin[2]), 0);
      checkOutput("wrap S4 step", int'(obsStep[2]), 1);
      checkOutput("wrap S4 err", int'(obsErr[2]), 0);

      // Illegal two-bit jump 00000 -> 00011 (binary 2).
      applyStimulus(5'b00011);
      repeat (3) waitEdge();
      checkOutput("jump S2 bin", int'(obsBin[0]), 2);
      checkOutput("jump S2 step", int'(obsStep[0]), 2);
      checkOutput("jump S2 err", int'(obsErr[0]), 1);
      repeat (20) waitEdge();
      for (int k = 0; k < 3; k++) checkOutput($sformatf("sticky S%0d err", k + 2), int'(obsErr[k]), 1);
      @(negedge clk);
      errClr = 1'b1;
      waitEdge();
      for (int k = 0; k < 3; k++) checkOutput($sformatf("clear S%0d err", k + 2), int'(obsErr[k]), 0);
      @(negedge clk);
      errClr = 1'b0;

      // Clear on the very edge an illegal jump (bin 2 -> 6) lands in S2: set wins.
      applyStimulus(5'b00101);
      waitEdge();
      waitEdge();
      @(negedge clk);
      errClr = 1'b1;
      waitEdge();
      checkOutput("setclr S2 err", int'(obsErr[0]), 1);
      checkOutput("setclr S2 bin", int'(obsBin[0]), 6);
      checkOutput("setclr S3 err", int'(obsErr[1]), 0);
      @(negedge clk);
      errClr = 1'b0;
      waitEdge();
      checkOutput("setclr S3 late err", int'(obsErr[1]), 1);

      // Reach binary 7, put binary 8 in flight, then reset asynchronously.
      applyStimulus(5'b00100);
      repeat (6) waitEdge();
      for (int k = 0; k < 3; k++) checkOutput($sformatf("pre-rst S%0d bin", k + 2), int'(obsBin[k]), 7);
      applyStimulus(5'b01100);
      waitEdge();
      @(negedge clk);
      ptrGray = 5'b00101;
      #1;
      reset = 1'b1;
      #1;
      checkAllZero("async rst");
      @(negedge clk);
      reset = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         waitEdge();
         for (int k = 0; k < 3; k++) begin
            automatic int s = k + 2;
            checkOutput($sformatf("post-rst e%0d S%0d gray", e, s), int'(obsGray[k]), (e >= s) ? 5 : 0);
            checkOutput($sformatf("post-rst e%0d S%0d bin", e, s), int'(obsBin[k]), (e >= s + 1) ? 6 : 0);
            checkOutput($sformatf("post-rst e%0d S%0d err", e, s), int'(obsErr[k]), (e >= s + 1) ? 1 : 0);
         end
      end
      checkOutput("post-rst S4 step", int'(obsStep[2]), 6);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
- Parametrised destination-domain synchroniser for async-FIFO Gray-coded pointers. Successor to the fixed 2-flop pointer sync.
- Configurable stage depth and pointer width.
- Adds Gray-to-binary decode, a change strobe, a step count (increments since the last sample), and a sticky detector for illegal multi-bit Gray transitions.
- Instantiated twice per async FIFO: write pointer into the read domain, read pointer into the write domain.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; pointer width PW = ADDR_WIDTH+1 (extra wrap bit).
- SYNC_STAGES, 2, number of metastability flops; legal range 2..4. Elaboration-time error outside this range.
- MAX_STEP, 1, largest legal binary advance per destination sample. A step > MAX_STEP flags an error.

Ports:
- clk  in  1  destination-domain clock
- reset  in  1  reset; asynchronous, active-high
- ptr_gray  in  PW  Gray pointer, registered in the source domain
- err_clr  in  1  synchronous clear of gray_err
- sync_gray  out  PW  synchronised Gray pointer
- sync_bin  out  PW  binary decode of sync_gray, registered
- changed  out  1  one-cycle pulse, aligned with sync_bin, when the binary value updated
- step  out  PW  (new sync_bin − previous sync_bin) mod 2^PW, aligned with changed
- gray_err  out  1  sticky: illegal transition seen

Behaviour:
- Reset (async assert, sync-safe deassert is the integrator's responsibility): all stage flops, sync_gray, sync_bin, step, changed and gray_err = 0. Reset mid-operation discards in-flight samples immediately.
- Stage chain: stg[0] <= ptr_gray; stg[i] <= stg[i-1]; sync_gray = stg[SYNC_STAGES-1].
  - Latency: ptr_gray to sync_gray = SYNC_STAGES clk edges.
  - No logic between stages.
- Decode stage, one flop after sync_gray:
  - sync_bin <= gray2bin(sync_gray), where b[PW-1] = g[PW-1] and b[i] = b[i+1] ^ g[i].
  - Latency: ptr_gray to sync_bin = SYNC_STAGES+1 edges.
- Delta, same edge as the sync_bin update:
  - d = gray2bin(sync_gray) − sync_bin, modulo 2^PW (wrap-around natural).
  - step <= d.
  - changed <= (d != 0).
  - When the input is unchanged: changed = 0 and step = 0.
- Error detection, same edge:
  - Flag if popcount(sync_gray ^ prev_gray) > 1, where prev_gray is the Gray value decoded last cycle.
  - Flag if d > MAX_STEP (unsigned).
- gray_err next-state:
  - Set if any flag is raised.
  - Otherwise cleared if err_clr.
  - Otherwise hold.
  - Set wins over a simultaneous err_clr.
- Errors never alter sync_gray, sync_bin or step; data still propagates.
- Wrap: binary 2^PW−1 → 0 is a legal single-bit Gray change. Gives step = 1, no error.
- The first sample after reset compares against 0. A nonzero first input equal to a legal single step is not an error.

Test Plan:
1. Reset, then hold ptr_gray = 0 for 10 cycles → all outputs 0, changed never asserts.
2. SYNC_STAGES = 2, PW = 5: drive ptr_gray 00000 → 00001 at edge 0.
   - sync_gray = 00001 after 2 edges.
   - sync_bin = 1, changed = 1, step = 1 after 3 edges.
   - changed = 0 the following cycle.
3. Wrap: step through all 32 Gray codes with one code per 4 cycles, ending at 10000 (bin 31) → 00000.
   - sync_bin = 0, step = 1, gray_err stays 0 throughout.
4. Illegal jump: ptr_gray 00000 → 00011 (bin 2) → sync_bin = 2, step = 2, gray_err = 1. It stays 1 for 20 cycles.
   - Then pulse err_clr → gray_err = 0 next edge.
5. Simultaneous set and clear: assert err_clr on the same edge as an illegal jump → gray_err = 1.
6. Reset mid-operation: assert reset while sync_bin = 7 and a new value is in the stage chain.
   - All outputs 0 immediately, without waiting for a clk edge.
   - After release with ptr_gray = 00101 (bin 6), sync_bin = 6 after 3 edges.
   - gray_err = 1 (step 6 > MAX_STEP).
7. Repeat scenarios 2 and 6 with SYNC_STAGES = 3 and 4 → latency scales as SYNC_STAGES to sync_gray and SYNC_STAGES+1 to sync_bin.
